// File: rtl/reg_bank_pkg.sv
// Shared mode constants, decode struct and parameter-slicing helpers for the
// synchronous control/status register bank.
package reg_bank_pkg;

    localparam logic [1:0] REG_MODE_RW  = 2'd0;
    localparam logic [1:0] REG_MODE_RO  = 2'd1;
    localparam logic [1:0] REG_MODE_W1C = 2'd2;

    // Upper bounds for the helper argument widths; the bank checks its own
    // parameters against these at elaboration.
    localparam int MAX_REGS       = 256;
    localparam int MAX_DATA_WIDTH = 64;
    localparam int MODES_W        = 2 * MAX_REGS;
    localparam int RESETS_W       = MAX_DATA_WIDTH * MAX_REGS;

    typedef logic [MODES_W-1:0]        modes_vec_t;
    typedef logic [RESETS_W-1:0]       resets_vec_t;
    typedef logic [MAX_DATA_WIDTH-1:0] max_word_t;

    // Per-cycle classification of the bus request.
    typedef struct packed {
        logic rd_ok;
        logic wr_ok;
        logic rd_bad;
        logic illegal;
    } req_dec_t;

    function automatic logic [1:0] mode_of(input modes_vec_t modes, input int idx);
        return modes[2*idx +: 2];
    endfunction

    function automatic max_word_t reset_of(input resets_vec_t resets,
                                           input int data_width, input int idx);
        resets_vec_t w_shifted;
        w_shifted = resets >> (data_width * idx);
        return max_word_t'(w_shifted);
    endfunction

endpackage

// File: rtl/reg_bank_if.sv
// Host bus between a master and the register bank.
// Handshake: a request exists in any cycle with en high; the bank has no ready and
// never stalls, and rvalid marks rdata for exactly one cycle, one cycle after a read.
interface reg_bank_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic                    en;
    logic                    rd;
    logic                    wr;
    logic [DATA_WIDTH/8-1:0] be;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rvalid;
    logic                    err;

    modport master (
        output en, rd, wr, be, addr, wdata,
        input  rdata, rvalid, err
    );

    modport slave (
        input  en, rd, wr, be, addr, wdata,
        output rdata, rvalid, err
    );

endinterface

// File: rtl/reg_bank_cell.sv
// One register of the bank: read/write, live read-only, or write-1-to-clear sticky
// status, selected by MODE at elaboration.
module reg_bank_cell
    import reg_bank_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 16,
    parameter logic [1:0]            MODE        = REG_MODE_RW,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_we,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH-1:0]   i_set,
    input  logic [DATA_WIDTH-1:0]   i_value,
    output logic [DATA_WIDTH-1:0]   o_q,
    output logic [DATA_WIDTH-1:0]   o_rd_value
);

    localparam int NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] w_bit_en;

    for (genvar k = 0; k < NBYTES; k++) begin : g_bit_en
        assign w_bit_en[8*k +: 8] = {8{i_be[k]}};
    end

    if (MODE == REG_MODE_RW) begin : g_rw
        logic [DATA_WIDTH-1:0] r_q;
        logic                  w_unused;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_q <= RESET_VALUE;
            end else if (i_we) begin
                r_q <= (r_q & ~w_bit_en) | (i_wdata & w_bit_en);
            end
        end

        assign o_q        = r_q;
        assign o_rd_value = r_q;
        assign w_unused   = ^{i_set, i_value};
    end else if (MODE == REG_MODE_W1C) begin : g_w1c
        logic [DATA_WIDTH-1:0] r_q;
        logic [DATA_WIDTH-1:0] w_clear;
        logic                  w_unused;

        // Set is applied after clear so a simultaneous set always wins.
        assign w_clear = i_we ? (i_wdata & w_bit_en) : '0;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_q <= RESET_VALUE;
            end else begin
                r_q <= (r_q & ~w_clear) | i_set;
            end
        end

        assign o_q        = r_q;
        assign o_rd_value = r_q;
        assign w_unused   = ^i_value;
    end else if (MODE == REG_MODE_RO) begin : g_ro
        logic w_unused;

        assign o_q        = '0;
        assign o_rd_value = i_value;
        assign w_unused   = ^{clk, reset, i_we, i_wdata, i_set, w_bit_en};
    end else begin : g_bad_mode
        $fatal(1, "reg_bank_cell: register mode 3 is illegal");
        assign o_q        = '0;
        assign o_rd_value = '0;
    end

endmodule

// File: rtl/reg_bank.sv
// Parametrised synchronous control/status register bank: address decode, legality
// check, read mux and registered bus responses around NUM_REGS register cells.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int                             ADDR_WIDTH   = 8,
    parameter int                             DATA_WIDTH   = 16,
    parameter int                             NUM_REGS     = 32,
    parameter logic [2*NUM_REGS-1:0]          MODES        = '0,
    parameter logic [DATA_WIDTH*NUM_REGS-1:0] RESET_VALUES = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    reg_bank_if.slave                      bus,
    input  logic [DATA_WIDTH*NUM_REGS-1:0] values,
    input  logic [DATA_WIDTH*NUM_REGS-1:0] set_bits,
    output logic [DATA_WIDTH*NUM_REGS-1:0] regs,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int          AW1        = ADDR_WIDTH + 1;
    localparam modes_vec_t  MODES_EXT  = modes_vec_t'(MODES);
    localparam resets_vec_t RESETS_EXT = resets_vec_t'(RESET_VALUES);

    if ((DATA_WIDTH % 8 != 0) || (DATA_WIDTH < 8) || (DATA_WIDTH > MAX_DATA_WIDTH)) begin : g_bad_width
        $fatal(1, "reg_bank: DATA_WIDTH must be a multiple of 8 between 8 and %0d", MAX_DATA_WIDTH);
    end

    if ((NUM_REGS < 1) || (NUM_REGS > MAX_REGS) ||
        ((ADDR_WIDTH < 31) && (NUM_REGS > (1 << ADDR_WIDTH)))) begin : g_bad_count
        $fatal(1, "reg_bank: NUM_REGS does not fit the address space");
    end

    req_dec_t              w_dec;
    logic                  w_in_range;
    logic [NUM_REGS-1:0]   w_we;
    logic [DATA_WIDTH-1:0] w_rd_value [NUM_REGS];
    logic [DATA_WIDTH-1:0] w_rd_mux;

    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;
    logic                  r_err;
    logic [NUM_REGS-1:0]   r_wr_pulse;

    // Widened compare so NUM_REGS == 2^ADDR_WIDTH is still representable.
    assign w_in_range = {1'b0, bus.addr} < AW1'(NUM_REGS);

    always_comb begin
        w_dec         = '0;
        w_dec.wr_ok   = bus.en & bus.wr & ~bus.rd & w_in_range;
        w_dec.rd_ok   = bus.en & bus.rd & ~bus.wr & w_in_range;
        w_dec.illegal = bus.en & ((bus.rd & bus.wr) | ((bus.rd | bus.wr) & ~w_in_range));
        w_dec.rd_bad  = w_dec.illegal & bus.rd;
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
        localparam logic [1:0] MODE_I = mode_of(MODES_EXT, i);

        // Writes to read-only slots are silently dropped and raise no strobe.
        assign w_we[i] = w_dec.wr_ok & (bus.addr == ADDR_WIDTH'(i)) & (MODE_I != REG_MODE_RO);

        reg_bank_cell #(
            .DATA_WIDTH  (DATA_WIDTH),
            .MODE        (MODE_I),
            .RESET_VALUE (DATA_WIDTH'(reset_of(RESETS_EXT, DATA_WIDTH, i)))
        ) u_cell (
            .clk        (clk),
            .reset      (reset),
            .i_we       (w_we[i]),
            .i_be       (bus.be),
            .i_wdata    (bus.wdata),
            .i_set      (set_bits[DATA_WIDTH*i +: DATA_WIDTH]),
            .i_value    (values[DATA_WIDTH*i +: DATA_WIDTH]),
            .o_q        (regs[DATA_WIDTH*i +: DATA_WIDTH]),
            .o_rd_value (w_rd_value[i])
        );
    end

    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.addr == ADDR_WIDTH'(i)) begin
                w_rd_mux = w_rd_value[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
            r_err      <= 1'b0;
            r_wr_pulse <= '0;
        end else begin
            r_rvalid   <= w_dec.rd_ok | w_dec.rd_bad;
            r_err      <= w_dec.illegal;
            r_wr_pulse <= w_we;
            if (w_dec.rd_ok) begin
                r_rdata <= w_rd_mux;
            end else if (w_dec.rd_bad) begin
                r_rdata <= '0;
            end
        end
    end

    assign bus.rdata  = r_rdata;
    assign bus.rvalid = r_rvalid;
    assign bus.err    = r_err;
    assign wr_pulse   = r_wr_pulse;

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against an array-based model.
module tb_reg_bank;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int NR = 12;
    localparam int BW = DW / 8;
    localparam int VW = DW * NR;

    localparam int M_RW  = 0;
    localparam int M_RO  = 1;
    localparam int M_W1C = 2;

    // Packed high register first: reg11 .. reg0.
    localparam logic [2*NR-1:0] MODES = {2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd1,
                                         2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
    localparam logic [VW-1:0] RESETS = {16'h0F0F, 16'h0000, 16'h00FF, 16'h0000,
                                        16'h0000, 16'h0000, 16'h0000, 16'h8001,
                                        16'h0000, 16'h5555, 16'hBEEF, 16'h1234};

    // Same configuration written index-first, as the model sees it.
    int          mode_tab [NR] = '{M_RW, M_RW, M_RW, M_RW, M_W1C, M_W1C,
                                   M_RO, M_RO, M_W1C, M_RW, M_RO, M_W1C};
    logic [DW-1:0] rst_tab [NR] = '{16'h1234, 16'hBEEF, 16'h5555, 16'h0000,
                                    16'h8001, 16'h0000, 16'h0000, 16'h0000,
                                    16'h0000, 16'h00FF, 16'h0000, 16'h0F0F};

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [VW-1:0] values;
    logic [VW-1:0] set_bits;
    logic [VW-1:0] regs;
    logic [NR-1:0] wr_pulse;

    reg_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    reg_bank #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .NUM_REGS     (NR),
        .MODES        (MODES),
        .RESET_VALUES (RESETS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .values   (values),
        .set_bits (set_bits),
        .regs     (regs),
        .wr_pulse (wr_pulse)
    );

    // Clock and reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic drive(input bit e, input bit r, input bit w, input logic [BW-1:0] b,
                         input int a, input logic [DW-1:0] d);
        bus.en    = e;
        bus.rd    = r;
        bus.wr    = w;
        bus.be    = b;
        bus.addr  = AW'(a);
        bus.wdata = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, 0, '0);
    endtask

    task automatic set_slice(input int i, input logic [DW-1:0] v);
        set_bits[i*DW +: DW] = v;
    endtask

    task automatic rand_inputs();
        reset     = ($urandom_range(0, 63) == 0);
        bus.en    = ($urandom_range(0, 9) < 8);
        bus.rd    = 1'($urandom_range(0, 1));
        bus.wr    = 1'($urandom_range(0, 1));
        bus.be    = BW'($urandom_range(0, 3));
        bus.addr  = AW'($urandom_range(0, NR + 2));
        bus.wdata = DW'($urandom);
        for (int i = 0; i < NR; i++) begin
            values[i*DW +: DW]   = DW'($urandom);
            set_bits[i*DW +: DW] = ($urandom_range(0, 3) == 0) ? DW'($urandom & $urandom) : '0;
        end
    endtask

    // Behavioural model: register contents plus the responses owed next cycle.
    logic [DW-1:0] m_reg [NR];
    logic [DW-1:0] exp_rdata = '0;
    bit            exp_rvalid = 1'b0;
    bit            exp_err = 1'b0;
    logic [NR-1:0] exp_wr_pulse = '0;
    bit            model_live = 1'b0;

    function automatic logic [VW-1:0] exp_regs();
        logic [VW-1:0] v;
        for (int i = 0; i < NR; i++) begin
            v[i*DW +: DW] = (mode_tab[i] == M_RO) ? '0 : m_reg[i];
        end
        return v;
    endfunction

    task automatic model_step();
        int            a;
        bit            in_rng;
        bit            wr_ok;
        bit            rd_ok;
        bit            bad;
        logic [DW-1:0] mask;
        logic [DW-1:0] clr;
        if (reset) begin
            for (int i = 0; i < NR; i++) begin
                m_reg[i] = (mode_tab[i] == M_RO) ? '0 : rst_tab[i];
            end
            exp_rdata    = '0;
            exp_rvalid   = 1'b0;
            exp_err      = 1'b0;
            exp_wr_pulse = '0;
            return;
        end
        a      = int'(bus.addr);
        in_rng = (a < NR);
        wr_ok  = bus.en && bus.wr && !bus.rd && in_rng;
        rd_ok  = bus.en && bus.rd && !bus.wr && in_rng;
        bad    = bus.en && (bus.rd || bus.wr) && !(wr_ok || rd_ok);

        exp_err    = bad;
        exp_rvalid = rd_ok || (bad && bus.rd);
        if (rd_ok) begin
            exp_rdata = (mode_tab[a] == M_RO) ? values[a*DW +: DW] : m_reg[a];
        end else if (bad && bus.rd) begin
            exp_rdata = '0;
        end
        exp_wr_pulse = '0;
        if (wr_ok && mode_tab[a] != M_RO) begin
            exp_wr_pulse[a] = 1'b1;
        end

        for (int k = 0; k < BW; k++) begin
            mask[8*k +: 8] = {8{bus.be[k]}};
        end
        for (int i = 0; i < NR; i++) begin
            if (mode_tab[i] == M_RW) begin
                if (wr_ok && a == i) begin
                    m_reg[i] = (m_reg[i] & ~mask) | (bus.wdata & mask);
                end
            end else if (mode_tab[i] == M_W1C) begin
                clr      = (wr_ok && a == i) ? (bus.wdata & mask) : '0;
                m_reg[i] = (m_reg[i] & ~clr) | set_bits[i*DW +: DW];
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            model_live = 1'b1;
        end
    end

    // Scoreboard compare, every cycle once the model has seen an edge
    initial begin
        forever begin
            @(negedge clk);
            if (model_live) begin
                check("rdata", bus.rdata, exp_rdata);
                check("rvalid", bus.rvalid, exp_rvalid);
                check("err", bus.err, exp_err);
                check("wr_pulse", wr_pulse, exp_wr_pulse);
                check("regs", regs, exp_regs());
            end
        end
    end

    initial begin
        values   = '0;
        set_bits = '0;
        idle();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rdata", bus.rdata, '0);
        check("reset_rvalid", bus.rvalid, '0);
        check("reset_wr_pulse", wr_pulse, '0);

        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, '0, 0, '0);
        @(negedge clk);
        check("rd0_rdata", bus.rdata, 16'h1234);
        check("rd0_rvalid", bus.rvalid, 1'b1);

        drive(1'b1, 1'b0, 1'b1, 2'b10, 3, 16'hABCD);
        @(negedge clk);
        check("wr3_pulse", wr_pulse, 12'h008);
        drive(1'b1, 1'b1, 1'b0, '0, 3, '0);
        @(negedge clk);
        check("rd3_rdata", bus.rdata, 16'hAB00);
        check("wr3_pulse_once", wr_pulse, '0);

        idle();
        set_slice(5, 16'h00F0);
        @(negedge clk);
        set_slice(5, 16'h0000);
        drive(1'b1, 1'b0, 1'b1, 2'b11, 5, 16'h0030);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, '0, 5, '0);
        @(negedge clk);
        check("rd5_w1c", bus.rdata, 16'h00C0);

        idle();
        set_slice(5, 16'h0010);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 2'b11, 5, 16'h0010);
        @(negedge clk);
        set_slice(5, 16'h0000);
        drive(1'b1, 1'b1, 1'b0, '0, 5, '0);
        @(negedge clk);
        check("rd5_set_wins", bus.rdata, 16'h00D0);
        check("regs5_slice", regs[5*DW +: DW], 16'h00D0);

        values[7*DW +: DW] = 16'h5A5A;
        drive(1'b1, 1'b1, 1'b0, '0, 7, '0);
        @(negedge clk);
        values = '0;
        check("rd7_ro", bus.rdata, 16'h5A5A);
        drive(1'b1, 1'b0, 1'b1, 2'b11, 7, 16'hFFFF);
        @(negedge clk);
        check("wr7_no_pulse", wr_pulse, '0);
        check("wr7_no_err", bus.err, 1'b0);
        check("regs7_slice", regs[7*DW +: DW], '0);

        drive(1'b1, 1'b1, 1'b0, '0, NR, '0);
        @(negedge clk);
        check("oor_rdata", bus.rdata, '0);
        check("oor_rvalid", bus.rvalid, 1'b1);
        check("oor_err", bus.err, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 2'b11, 2, 16'h0000);
        @(negedge clk);
        check("rdwr_err", bus.err, 1'b1);
        check("rdwr_no_pulse", wr_pulse, '0);
        drive(1'b1, 1'b1, 1'b0, '0, 2, '0);
        @(negedge clk);
        check("rd2_unchanged", bus.rdata, 16'h5555);

        drive(1'b1, 1'b0, 1'b1, 2'b11, 1, 16'h1111);
        @(negedge clk);
        check("wr1_pulse", wr_pulse, 12'h002);
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 2'b11, 1, 16'h2222);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, '0, 1, '0);
        @(negedge clk);
        reset = 1'b0;
        check("reset_drop_pulse", wr_pulse, '0);
        check("reset_drop_rvalid", bus.rvalid, 1'b0);
        drive(1'b1, 1'b1, 1'b0, '0, 1, '0);
        @(negedge clk);
        check("rd1_reset_value", bus.rdata, 16'hBEEF);

        repeat (3000) begin
            @(negedge clk);
            rand_inputs();
        end
        @(negedge clk);
        reset    = 1'b0;
        set_bits = '0;
        idle();
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
